cpu_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 16-bit micro CPU datapath: program counter, program memory, file register and ALU16bit.
- Fetches an instruction through a req/ready memory handshake, latches it, then steps decode, execute and writeback.
- Drives register-file selects and write enable, ALU function, and PC increment/load.
- Replaces the purely combinational control_unit path, so memory may take wait states.

---
 rtl/cpu_seq_pkg.sv | 37 +++
 rtl/seq_watchdog.sv | 33 +++
 rtl/cpu_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer: state
// encoding, function-code constants, instruction field positions and a
// small decode helper.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_WAIT_MEM  = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_e;

    // Function codes in ir[3:0]; 0x0-0xB are ALU operations.
    localparam logic [3:0] FUNC_ALU_MAX = 4'hB;
    localparam logic [3:0] FUNC_JMP     = 4'hC;
    localparam logic [3:0] FUNC_RSV     = 4'hD;
    localparam logic [3:0] FUNC_NOP     = 4'hE;
    localparam logic [3:0] FUNC_HLT     = 4'hF;

    // Instruction layout: [15:12] src1, [11:8] src2, [7:4] dest, [3:0] func.
    localparam int FIELD_W  = 4;
    localparam int SRC1_LSB = 12;
    localparam int SRC2_LSB = 8;
    localparam int DEST_LSB = 4;
    localparam int FUNC_LSB = 0;
    // Jump target occupies the three upper fields.
    localparam int JMP_LSB  = 4;
    localparam int JMP_W    = 12;

    function automatic logic is_alu_func(input logic [3:0] func);
        return (func <= FUNC_ALU_MAX);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Memory-wait timeout down-counter. start reloads TIMEOUT, tick counts one
// waiting cycle, expired flags the tick that exhausts the budget.
module seq_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int TW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic tick,
    output logic expired
);

    localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT);
    localparam logic [TW-1:0] ONE      = TW'(1);

    logic [TW-1:0] count;

    // Reload on start, otherwise count down while ticking, saturating at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= LOAD_VAL;
        end else if (tick && (count != '0)) begin
            count <= count - ONE;
        end
    end

    // The last remaining cycle is being consumed without a response.
    assign expired = tick && (count == ONE);

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit micro CPU datapath.
// Fetches through a req/ready handshake, then steps decode, execute and
// writeback, driving register-file selects, ALU function and PC control.
// Optional memory-wait timeout: define SEQ_MEM_TIMEOUT_EN (adds the
// MEM_TIMEOUT parameter and the sticky fault flag).
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int CNT_W = 16
`ifdef SEQ_MEM_TIMEOUT_EN
    , parameter int MEM_TIMEOUT = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [11:0]      pc,
    output logic             mem_req,
    output logic [11:0]      mem_addr,
    input  logic             mem_ready,
    input  logic [15:0]      mem_rdata,
    output logic [15:0]      ir,
    output logic [3:0]       rf_src1,
    output logic [3:0]       rf_src2,
    output logic [3:0]       rf_dest,
    output logic [3:0]       alu_op,
    output logic             rf_we,
    output logic             pc_inc,
    output logic             pc_load,
    output logic [11:0]      pc_load_val,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] retired,
    output seq_state_e       seq_state
);

    // Memory handshake: mem_req rises the cycle after FETCH and stays high,
    // with mem_addr stable, until a cycle in which mem_ready is sampled high;
    // that cycle transfers mem_rdata into ir and mem_req falls next cycle.
    // mem_ready is ignored while mem_req is low.

    localparam logic [CNT_W-1:0] RETIRE_ONE = CNT_W'(1);

    seq_state_e  state;
    seq_state_e  next_state;
    logic [3:0]  func;
    logic        timeout_hit;

    logic        mem_req_d;
    logic        pc_inc_d;
    logic        pc_load_d;
    logic        rf_we_d;
    logic        halted_d;
    logic        ir_load;
    logic        addr_load;
    logic        retire;

    assign func        = ir[FUNC_LSB +: FIELD_W];
    assign rf_src1     = ir[SRC1_LSB +: FIELD_W];
    assign rf_src2     = ir[SRC2_LSB +: FIELD_W];
    assign rf_dest     = ir[DEST_LSB +: FIELD_W];
    assign alu_op      = func;
    assign pc_load_val = ir[JMP_LSB +: JMP_W];
    assign seq_state   = state;

`ifdef SEQ_MEM_TIMEOUT_EN
    logic wd_start;
    logic wd_tick;
    logic wd_expired;

    // Budget is armed in FETCH so it is full on the first WAIT_MEM cycle.
    assign wd_start = (state == ST_FETCH);
    assign wd_tick  = (state == ST_WAIT_MEM) && !mem_ready;

    seq_watchdog #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (wd_start),
        .tick    (wd_tick),
        .expired (wd_expired)
    );

    assign timeout_hit = wd_expired;

    // Sticky fault: only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (timeout_hit) begin
            fault <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fault       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the next values of every registered strobe.
    always_comb begin
        next_state = state;
        mem_req_d  = 1'b0;
        pc_inc_d   = 1'b0;
        pc_load_d  = 1'b0;
        rf_we_d    = 1'b0;
        ir_load    = 1'b0;
        addr_load  = 1'b0;
        retire     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                addr_load  = 1'b1;
                mem_req_d  = 1'b1;
                next_state = ST_WAIT_MEM;
            end
            ST_WAIT_MEM: begin
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc_d   = 1'b1;
                    next_state = ST_DECODE;
                end else if (timeout_hit) begin
                    next_state = ST_HALT;
                end else begin
                    mem_req_d  = 1'b1;
                end
            end
            ST_DECODE: begin
                // pc_load is raised here so it lands in EXECUTE, one cycle
                // after the pc_inc pulse, and the target overrides it.
                pc_load_d  = (func == FUNC_JMP);
                next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (is_alu_func(func)) begin
                    rf_we_d    = 1'b1;
                    next_state = ST_WRITEBACK;
                end else begin
                    // JMP, NOP, reserved and HLT all retire here.
                    retire = 1'b1;
                    if (func == FUNC_HLT) next_state = ST_HALT;
                    else if (run)         next_state = ST_FETCH;
                    else                  next_state = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                retire     = 1'b1;
                next_state = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                next_state = ST_HALT;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
        halted_d = (next_state == ST_HALT);
    end

    // Registered outputs, instruction register, fetch address and counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            ir       <= '0;
            rf_we    <= 1'b0;
            pc_inc   <= 1'b0;
            pc_load  <= 1'b0;
            halted   <= 1'b0;
            retired  <= '0;
        end else begin
            mem_req <= mem_req_d;
            rf_we   <= rf_we_d;
            pc_inc  <= pc_inc_d;
            pc_load <= pc_load_d;
            halted  <= halted_d;
            if (addr_load) mem_addr <= pc;
            if (ir_load)   ir       <= mem_rdata;
            if (retire)    retired  <= retired + RETIRE_ONE;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: one task per scenario, inline checks,
// a small memory responder with a programmable number of wait cycles.
module tb_cpu_sequencer;
    import cpu_seq_pkg::*;

    localparam int TB_CNT_W = 3;

    logic                clk;
    logic                reset;
    logic                run;
    logic [11:0]         pc;
    logic                mem_req;
    logic [11:0]         mem_addr;
    logic                mem_ready;
    logic [15:0]         mem_rdata;
    logic [15:0]         ir;
    logic [3:0]          rf_src1;
    logic [3:0]          rf_src2;
    logic [3:0]          rf_dest;
    logic [3:0]          alu_op;
    logic                rf_we;
    logic                pc_inc;
    logic                pc_load;
    logic [11:0]         pc_load_val;
    logic                halted;
    logic                fault;
    logic [TB_CNT_W-1:0] retired;
    seq_state_e          seq_state;

    int total;
    int bad;
    int ready_delay;
    int wait_cnt;

    cpu_sequencer #(
        .CNT_W (TB_CNT_W)
`ifdef SEQ_MEM_TIMEOUT_EN
        , .MEM_TIMEOUT (4)
`endif
    ) dut (
        .clk (clk), .reset (reset), .run (run), .pc (pc),
        .mem_req (mem_req), .mem_addr (mem_addr), .mem_ready (mem_ready),
        .mem_rdata (mem_rdata), .ir (ir), .rf_src1 (rf_src1),
        .rf_src2 (rf_src2), .rf_dest (rf_dest), .alu_op (alu_op),
        .rf_we (rf_we), .pc_inc (pc_inc), .pc_load (pc_load),
        .pc_load_val (pc_load_val), .halted (halted), .fault (fault),
        .retired (retired), .seq_state (seq_state)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: answers after ready_delay cycles of mem_req.
    always @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign mem_ready = mem_req && (wait_cnt >= ready_delay);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; pc = 12'h000; mem_rdata = 16'h0000; ready_delay = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ir !== 16'h0000) begin bad++; $display("FAIL reset_ir got=%h want=0000", ir); end
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL reset_mem_addr got=%h want=000", mem_addr); end
        total++; if ({rf_we, pc_inc, pc_load} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b want=000", {rf_we, pc_inc, pc_load}); end
        total++; if ({halted, fault} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b want=00", {halted, fault}); end
        total++; if (retired !== 3'd0) begin bad++; $display("FAIL reset_retired got=%0d want=0", retired); end
        repeat (3) step();
        total++; if (seq_state !== ST_IDLE || mem_req !== 1'b0) begin bad++; $display("FAIL idle_no_run state=%0d req=%b want state=0 req=0", seq_state, mem_req); end
    endtask

    task automatic test_alu_zero_wait();
        int we_n = 0, we_k = 0, req_n = 0, req_k = 0, inc_n = 0, inc_k = 0;
        pc = 12'h000; mem_rdata = 16'h1230; ready_delay = 0; run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) run = 1'b0;
            if (rf_we) begin we_n++; we_k = k; end
            if (mem_req) begin req_n++; req_k = k; end
            if (pc_inc) begin inc_n++; inc_k = k; end
            if (k == 2) begin
                total++; if (mem_addr !== 12'h000) begin bad++; $display("FAIL alu_mem_addr got=%h want=000", mem_addr); end
            end
            if (k == 3) begin
                total++; if (ir !== 16'h1230) begin bad++; $display("FAIL alu_ir got=%h want=1230", ir); end
                total++; if ({rf_src1, rf_src2, rf_dest} !== 12'h123) begin bad++; $display("FAIL alu_fields got=%h want=123", {rf_src1, rf_src2, rf_dest}); end
            end
            if (k == 5) begin
                total++; if (alu_op !== 4'h0) begin bad++; $display("FAIL alu_op got=%h want=0", alu_op); end
            end
        end
        total++; if (we_n !== 1 || we_k !== 5) begin bad++; $display("FAIL alu_rf_we count=%0d at=%0d want 1 at 5", we_n, we_k); end
        total++; if (req_n !== 1 || req_k !== 2) begin bad++; $display("FAIL alu_mem_req count=%0d at=%0d want 1 at 2", req_n, req_k); end
        total++; if (inc_n !== 1 || inc_k !== 3) begin bad++; $display("FAIL alu_pc_inc count=%0d at=%0d want 1 at 3", inc_n, inc_k); end
        total++; if (retired !== 3'd1) begin bad++; $display("FAIL alu_retired got=%0d want=1", retired); end
        total++; if (seq_state !== ST_IDLE) begin bad++; $display("FAIL alu_end_state got=%0d want=0", seq_state); end
    endtask

    task automatic test_wait_states();
        int we_k = 0, req_n = 0, req_first = 0, inc_n = 0, inc_k = 0;
        pc = 12'h5A5; mem_rdata = 16'h4567; ready_delay = 2; run = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 2) run = 1'b0;
            if (rf_we) we_k = k;
            if (mem_req) begin req_n++; if (req_first == 0) req_first = k; end
            if (pc_inc) begin inc_n++; inc_k = k; end
            if (k == 4) begin
                total++; if (ir !== 16'h1230) begin bad++; $display("FAIL wait_ir_early got=%h want=1230", ir); end
            end
            if (k == 5) begin
                total++; if (ir !== 16'h4567) begin bad++; $display("FAIL wait_ir got=%h want=4567", ir); end
            end
            if (k == 7) begin
                total++; if (alu_op !== 4'h7) begin bad++; $display("FAIL wait_alu_op got=%h want=7", alu_op); end
            end
        end
        total++; if (req_n !== 3 || req_first !== 2) begin bad++; $display("FAIL wait_mem_req count=%0d first=%0d want 3 from 2", req_n, req_first); end
        total++; if (mem_addr !== 12'h5A5) begin bad++; $display("FAIL wait_mem_addr got=%h want=5a5", mem_addr); end
        total++; if (we_k !== 7) begin bad++; $display("FAIL wait_rf_we at=%0d want=7", we_k); end
        total++; if (inc_n !== 1 || inc_k !== 5) begin bad++; $display("FAIL wait_pc_inc count=%0d at=%0d want 1 at 5", inc_n, inc_k); end
        total++; if (retired !== 3'd2) begin bad++; $display("FAIL wait_retired got=%0d want=2", retired); end
    endtask

    task automatic test_jmp();
        int we_n = 0, inc_k = 0, load_n = 0, load_k = 0, both_n = 0;
        pc = 12'h010; mem_rdata = 16'hABCC; ready_delay = 0; run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) run = 1'b0;
            if (rf_we) we_n++;
            if (pc_inc) inc_k = k;
            if (pc_load) begin load_n++; load_k = k; end
            if (pc_inc && pc_load) both_n++;
            if (k == 4) begin
                total++; if (pc_load_val !== 12'hABC) begin bad++; $display("FAIL jmp_target got=%h want=abc", pc_load_val); end
            end
        end
        total++; if (inc_k !== 3) begin bad++; $display("FAIL jmp_pc_inc at=%0d want=3", inc_k); end
        total++; if (load_n !== 1 || load_k !== 4) begin bad++; $display("FAIL jmp_pc_load count=%0d at=%0d want 1 at 4", load_n, load_k); end
        total++; if (we_n !== 0 || both_n !== 0) begin bad++; $display("FAIL jmp_no_we_overlap we=%0d overlap=%0d want 0 0", we_n, both_n); end
        total++; if (retired !== 3'd3 || seq_state !== ST_IDLE) begin bad++; $display("FAIL jmp_retire retired=%0d state=%0d want 3 0", retired, seq_state); end
    endtask

    task automatic test_back_to_back();
        int we_n = 0, req_n = 0, inc_n = 0, load_n = 0;
        pc = 12'h040; mem_rdata = 16'h123D; ready_delay = 0; run = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 4) mem_rdata = 16'h456E;
            if (k == 8) run = 1'b0;
            if (rf_we) we_n++;
            if (mem_req) req_n++;
            if (pc_inc) inc_n++;
            if (pc_load) load_n++;
            if (k == 3) begin
                total++; if (ir !== 16'h123D) begin bad++; $display("FAIL b2b_ir_rsv got=%h want=123d", ir); end
            end
            if (k == 5) begin
                total++; if (seq_state !== ST_FETCH) begin bad++; $display("FAIL b2b_refetch state=%0d want=1", seq_state); end
            end
        end
        total++; if (req_n !== 2 || inc_n !== 2) begin bad++; $display("FAIL b2b_fetches req=%0d inc=%0d want 2 2", req_n, inc_n); end
        total++; if (we_n !== 0 || load_n !== 0) begin bad++; $display("FAIL b2b_no_side we=%0d load=%0d want 0 0", we_n, load_n); end
        total++; if (ir !== 16'h456E) begin bad++; $display("FAIL b2b_ir_nop got=%h want=456e", ir); end
        total++; if (retired !== 3'd5 || seq_state !== ST_IDLE) begin bad++; $display("FAIL b2b_retire retired=%0d state=%0d want 5 0", retired, seq_state); end
    endtask

    task automatic test_run_drop_decode();
        int we_k = 0, req_n = 0;
        pc = 12'h020; mem_rdata = 16'h89A5; ready_delay = 0; run = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 3) run = 1'b0;
            if (rf_we) we_k = k;
            if (mem_req) req_n++;
        end
        total++; if (we_k !== 5 || req_n !== 1) begin bad++; $display("FAIL drop_complete we_at=%0d req=%0d want 5 1", we_k, req_n); end
        total++; if (seq_state !== ST_IDLE || retired !== 3'd6) begin bad++; $display("FAIL drop_idle state=%0d retired=%0d want 0 6", seq_state, retired); end
        pc = 12'h021; run = 1'b1;
        step();
        total++; if (seq_state !== ST_FETCH) begin bad++; $display("FAIL resume_fetch state=%0d want=1", seq_state); end
        step();
        run = 1'b0;
        total++; if (mem_req !== 1'b1 || mem_addr !== 12'h021) begin bad++; $display("FAIL resume_req req=%b addr=%h want 1 021", mem_req, mem_addr); end
        repeat (4) step();
        total++; if (retired !== 3'd7 || seq_state !== ST_IDLE) begin bad++; $display("FAIL resume_retire retired=%0d state=%0d want 7 0", retired, seq_state); end
    endtask

    task automatic test_halt();
        int req_n = 0, unhalted_n = 0;
        pc = 12'h030; mem_rdata = 16'h000F; ready_delay = 0; run = 1'b1;
        repeat (4) step();
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_early got=%b want=0", halted); end
        step();
        total++; if (halted !== 1'b1 || seq_state !== ST_HALT) begin bad++; $display("FAIL halt_enter halted=%b state=%0d want 1 6", halted, seq_state); end
        total++; if (retired !== 3'd0) begin bad++; $display("FAIL halt_retired_wrap got=%0d want=0", retired); end
        for (int k = 0; k < 20; k++) begin
            step();
            if (mem_req) req_n++;
            if (!halted) unhalted_n++;
        end
        total++; if (req_n !== 0 || unhalted_n !== 0) begin bad++; $display("FAIL halt_stays req=%0d unhalted=%0d want 0 0", req_n, unhalted_n); end
        run = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (halted !== 1'b0 || ir !== 16'h0000 || seq_state !== ST_IDLE) begin bad++; $display("FAIL halt_reset halted=%b ir=%h state=%0d want 0 0000 0", halted, ir, seq_state); end
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        pc = 12'h333; mem_rdata = 16'h1111; ready_delay = 1000; run = 1'b1;
        repeat (2) step();
        total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_wait_req_before got=%b want=1", mem_req); end
        #2;
        reset = 1'b1;
        #1;
        total++; if (mem_req !== 1'b0 || seq_state !== ST_IDLE) begin bad++; $display("FAIL rst_wait_async req=%b state=%0d want 0 0", mem_req, seq_state); end
        run = 1'b0;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_mem_timeout();
        int inc_n = 0, fault_n = 0;
        step();
        pc = 12'h050; mem_rdata = 16'h2222; ready_delay = 1000; run = 1'b1;
`ifdef SEQ_MEM_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            step();
            if (pc_inc) inc_n++;
            if (k == 5) begin
                total++; if (mem_req !== 1'b1 || fault !== 1'b0) begin bad++; $display("FAIL tmo_before req=%b fault=%b want 1 0", mem_req, fault); end
            end
            if (k == 6) begin
                total++; if (fault !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL tmo_fire fault=%b halted=%b req=%b want 1 1 0", fault, halted, mem_req); end
            end
        end
        total++; if (ir !== 16'h0000 || retired !== 3'd0 || inc_n !== 0) begin bad++; $display("FAIL tmo_side ir=%h retired=%0d inc=%0d want 0000 0 0", ir, retired, inc_n); end
        total++; if (seq_state !== ST_HALT || fault !== 1'b1) begin bad++; $display("FAIL tmo_sticky state=%0d fault=%b want 6 1", seq_state, fault); end
`else
        for (int k = 1; k <= 20; k++) begin
            step();
            if (pc_inc) inc_n++;
            if (fault) fault_n++;
        end
        total++; if (fault_n !== 0 || inc_n !== 0) begin bad++; $display("FAIL nowd_fault fault=%0d inc=%0d want 0 0", fault_n, inc_n); end
        total++; if (mem_req !== 1'b1 || seq_state !== ST_WAIT_MEM) begin bad++; $display("FAIL nowd_wait req=%b state=%0d want 1 2", mem_req, seq_state); end
`endif
        do_reset();
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        run = 1'b0;
        pc = 12'h000;
        mem_rdata = 16'h0000;
        ready_delay = 0;
        test_reset();
        test_alu_zero_wait();
        test_wait_states();
        test_jmp();
        test_back_to_back();
        test_run_drop_decode();
        test_halt();
        test_reset_in_wait();
        test_mem_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
